// File: rtl/spi_initiator_multi.sv
// SPI initiator: serialises DATA_W-bit words with runtime CPOL/CPHA, bit order and
// SCK divider, driving one of NUM_SS active-low selects with optional held-select bursts.
module spi_initiator_multi #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 8,
  localparam int SEL_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic              cfg_lsb_first,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [SEL_W-1:0]  tx_sel,
  input  logic              tx_last,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              sck,
  output logic [NUM_SS-1:0] ss_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int TC_W = $clog2(2 * DATA_W + 1);
  localparam logic [TC_W-1:0] TC_END  = TC_W'(2 * DATA_W);
  localparam logic [TC_W-1:0] TC_PENU = TC_W'(2 * DATA_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_XFER, S_HOLD, S_TRAIL, S_GAP} state_t;

  state_t            state, state_nx;
  logic [DIV_W-1:0]  cnt, div_q;
  logic [TC_W-1:0]   tcnt;
  logic [DATA_W-1:0] tx_sh, rx_sh;
  logic              cpha_q, lsb_q, last_q;
  logic              accept, tick, xfer_done, xfer_exit, toggle, leading, sample;
  logic              acc_cpha, acc_lsb;

  function automatic logic out_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_w(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  assign accept    = tx_valid && tx_ready;
  assign tick      = (cnt == '0);
  assign xfer_done = (tcnt == TC_END);
  assign xfer_exit = (state == S_XFER) && xfer_done;
  // The first SCK toggle is issued on the LEAD exit so it lands exactly H after select.
  assign toggle    = tick && ((state == S_LEAD) || ((state == S_XFER) && !xfer_done));
  assign leading   = ~tcnt[0];
  assign sample    = leading ^ cpha_q;
  assign acc_cpha  = (state == S_IDLE) ? cfg_cpha : cpha_q;
  assign acc_lsb   = (state == S_IDLE) ? cfg_lsb_first : lsb_q;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (accept) state_nx = S_LEAD;
      S_LEAD:  if (tick) state_nx = S_XFER;
      S_XFER:  if (xfer_done) state_nx = last_q ? S_TRAIL : S_HOLD;
      S_HOLD:  if (accept) state_nx = S_LEAD;
      S_TRAIL: if (tick) state_nx = S_GAP;
      S_GAP:   if (tick) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck      <= 1'b0;
      ss_n     <= '1;
      mosi     <= 1'b0;
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      cnt      <= '0;
      div_q    <= '0;
      tcnt     <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_ready <= (state_nx == S_IDLE) || (state_nx == S_HOLD);
      if (state == S_IDLE) sck <= cfg_cpol;

      if (accept) begin
        last_q <= tx_last;
        tcnt   <= '0;
        if (state == S_IDLE) begin
          cpha_q <= cfg_cpha;
          lsb_q  <= cfg_lsb_first;
          div_q  <= cfg_div;
          cnt    <= cfg_div;
          for (int unsigned i = 0; i < NUM_SS; i++) ss_n[i] <= (32'(tx_sel) != i);
        end else begin
          cnt <= div_q;
        end
        if (!acc_cpha) begin
          mosi  <= out_bit(tx_data, acc_lsb);
          tx_sh <= shift_w(tx_data, acc_lsb);
        end else begin
          tx_sh <= tx_data;
        end
      end else if (state != S_IDLE && state != S_HOLD) begin
        cnt <= (tick || xfer_exit) ? div_q : cnt - 1'b1;
      end

      if (toggle) begin
        sck  <= ~sck;
        tcnt <= tcnt + 1'b1;
        if (sample) begin
          rx_sh <= lsb_q ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
        end else if (cpha_q || tcnt != TC_PENU) begin
          mosi  <= out_bit(tx_sh, lsb_q);
          tx_sh <= shift_w(tx_sh, lsb_q);
        end
      end

      if (xfer_exit) begin
        rx_valid <= 1'b1;
        rx_data  <= rx_sh;
      end

      if (state == S_TRAIL && tick) ss_n <= '1;
    end
  end

endmodule

// File: tb/tb_spi_initiator_multi.sv
// Bench for spi_initiator_multi: SPI target model plus expected-word queues for
// both the word seen on mosi and the word returned on rx_data.
module tb_spi_initiator_multi;
  localparam int W   = 8;
  localparam int NSS = 4;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb_first = 1'b0;
  logic [DW-1:0] cfg_div = 8'd1;
  logic          tx_valid = 1'b0, tx_last = 1'b0;
  logic          tx_ready, rx_valid, busy, sck, mosi, miso;
  logic [W-1:0]  tx_data = '0, rx_data;
  logic [1:0]    tx_sel = '0;
  logic [NSS-1:0] ss_n;

  always #5 clk = ~clk;

  spi_initiator_multi #(.DATA_W(W), .NUM_SS(NSS), .DIV_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .cfg_lsb_first(cfg_lsb_first), .cfg_div(cfg_div), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_sel(tx_sel), .tx_last(tx_last),
    .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .sck(sck), .ss_n(ss_n),
    .mosi(mosi), .miso(miso)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  logic [W-1:0] exp_rx[$], exp_mosi[$], slv_q[$];
  logic lb = 1'b1;
  logic m_cpol = 1'b0, m_cpha = 1'b0, m_lsb = 1'b0;
  logic slv_miso = 1'b0;
  assign miso = lb ? mosi : slv_miso;

  // target model and observation state
  logic [W-1:0] cur = '0, rxw = '0;
  int si = 0, rcnt = 0;
  logic act, act_p = 1'b0, sck_p = 1'b0, mosi_p = 1'b0, ss0_p = 1'b1, lead, first_seen = 1'b0, seen_rise = 1'b0;
  int cyc = 0, t_ssfall = 0, t_first = 0, t_ssrise = 0, nrise = 0, last_rise = -1;
  int pmin = 0, pmax = 0, mosi_bad = 0, mosi_hi = 0, ss0_rise = 0, rdy_bad = 0, accepts = 0, gap_min = 0;

  function automatic logic bitof(input logic [W-1:0] w, input int i, input logic lsb);
    return lsb ? w[i] : w[W-1-i];
  endfunction

  function automatic logic [W-1:0] pop_slv();
    return (slv_q.size() != 0) ? slv_q.pop_front() : '0;
  endfunction

  task automatic clr_mon();
    nrise = 0; last_rise = -1; pmin = 1000000; pmax = 0; mosi_bad = 0; mosi_hi = 0;
    ss0_rise = 0; rdy_bad = 0; accepts = 0; gap_min = 1000000; seen_rise = 1'b0;
  endtask

  always @(negedge clk) begin
    cyc++;
    act = (ss_n != '1);
    if (act && !act_p) begin
      t_ssfall = cyc; first_seen = 1'b0; rcnt = 0; si = 0; rxw = '0;
      if (seen_rise && (cyc - t_ssrise) < gap_min) gap_min = cyc - t_ssrise;
      if (!m_cpha) begin cur = pop_slv(); slv_miso = bitof(cur, 0, m_lsb); end
    end
    if (!act && act_p) begin t_ssrise = cyc; seen_rise = 1'b1; end
    if (ss_n[0] && !ss0_p) ss0_rise++;
    if (act && sck != sck_p) begin
      if (!first_seen) begin first_seen = 1'b1; t_first = cyc; end
      lead = (sck != m_cpol);
      if (lead ^ m_cpha) begin
        rxw = m_lsb ? {mosi, rxw[W-1:1]} : {rxw[W-2:0], mosi};
        rcnt++;
        if (rcnt == W) begin
          rcnt = 0;
          if (exp_mosi.size() != 0) check("mosi_word", 32'(rxw), 32'(exp_mosi.pop_front()));
          else check("mosi_extra", 32'(exp_mosi.size()), 32'd1);
        end
      end else if (m_cpha) begin
        if (si == 0) cur = pop_slv();
        slv_miso = bitof(cur, si, m_lsb);
        si++;
        if (si == W) si = 0;
      end else begin
        si++;
        if (si == W) begin si = 0; cur = pop_slv(); end
        slv_miso = bitof(cur, si, m_lsb);
      end
    end
    if (sck && !sck_p) begin
      nrise++;
      if (last_rise >= 0) begin
        if (cyc - last_rise < pmin) pmin = cyc - last_rise;
        if (cyc - last_rise > pmax) pmax = cyc - last_rise;
      end
      last_rise = cyc;
    end
    if (mosi != mosi_p && !(sck_p && !sck)) mosi_bad++;
    if (act && mosi) mosi_hi++;
    if (tx_ready && act) rdy_bad++;
    if (tx_valid && tx_ready) accepts++;
    if (rx_valid) begin
      if (exp_rx.size() != 0) check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
      else check("rx_extra", 32'(rx_valid), 32'd0);
    end
    act_p = act; sck_p = sck; mosi_p = mosi; ss0_p = ss_n[0];
  end

  task automatic send(input logic [W-1:0] d, input logic [W-1:0] rsp, input logic [1:0] s, input logic l);
    int n;
    exp_mosi.push_back(d);
    exp_rx.push_back(lb ? d : rsp);
    if (!lb) slv_q.push_back(rsp);
    @(posedge clk); #1;
    tx_valid = 1'b1; tx_data = d; tx_sel = s; tx_last = l;
    n = 0;
    do begin @(negedge clk); n++; end while (!tx_ready && n < 2000);
    if (!tx_ready) check("accept_timeout", 32'(tx_ready), 32'd1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while ((busy || exp_rx.size() != 0) && n < 5000);
    if (n >= 5000) check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
    check({tag, "_rx_pending"}, 32'(exp_rx.size()), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ss_n"}, 32'(ss_n), 32'hF);
  endtask

  task automatic set_mode(input logic cpol, input logic cpha, input logic lsb, input logic [DW-1:0] div);
    cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb_first = lsb; cfg_div = div;
    m_cpol = cpol; m_cpha = cpha; m_lsb = lsb;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w6 [3];
    int n, k;
    repeat (2) @(negedge clk);
    #1;
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_ss_n", 32'(ss_n), 32'hF);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // 1: mode 0, div 1, MSB first, loopback
    lb = 1'b1; set_mode(1'b0, 1'b0, 1'b0, 8'd1); clr_mon();
    send(8'hA5, 8'h00, 2'd2, 1'b1);
    @(negedge clk);
    check("t1_ss_sel", 32'(ss_n), 32'b1011);
    wait_idle("t1");
    check("t1_lead", 32'(t_first - t_ssfall), 32'd2);
    check("t1_nrise", 32'(nrise), 32'd8);
    check("t1_pmin", 32'(pmin), 32'd4);
    check("t1_pmax", 32'(pmax), 32'd4);

    // 2: mode 3, div 0, target returns 0x3C
    lb = 1'b0; set_mode(1'b1, 1'b1, 1'b0, 8'd0);
    check("t2_sck_idle", 32'(sck), 32'd1);
    clr_mon();
    send(8'hC3, 8'h3C, 2'd1, 1'b1);
    wait_idle("t2");
    check("t2_mosi_on_fall", 32'(mosi_bad), 32'd0);
    check("t2_nrise", 32'(nrise), 32'd8);
    check("t2_sck_end", 32'(sck), 32'd1);

    // 3: burst under held select, config and select changes mid-burst ignored
    lb = 1'b0; set_mode(1'b0, 1'b0, 1'b0, 8'd1); clr_mon();
    send(8'h11, 8'h5E, 2'd0, 1'b0);
    cfg_div = 8'd3; cfg_lsb_first = 1'b1; cfg_cpha = 1'b1;
    send(8'h22, 8'hE7, 2'd3, 1'b1);
    wait_idle("t3");
    check("t3_nrise", 32'(nrise), 32'd16);
    check("t3_ss0_release", 32'(ss0_rise), 32'd1);

    // 4: mode 1, LSB first
    lb = 1'b1; set_mode(1'b0, 1'b1, 1'b1, 8'd1); clr_mon();
    send(8'h01, 8'h00, 2'd1, 1'b1);
    wait_idle("t4");
    check("t4_mosi_hi", 32'(mosi_hi), 32'd4);

    // 5: reset mid-word, then a clean word
    lb = 1'b1; set_mode(1'b0, 1'b0, 1'b0, 8'd1); clr_mon();
    send(8'h96, 8'h00, 2'd0, 1'b1);
    n = 0;
    while (nrise < 4 && n < 500) begin @(negedge clk); n++; end
    check("t5_reach_bit4", 32'(nrise), 32'd4);
    rst_n = 1'b0;
    #1;
    check("t5_rst_ss_n", 32'(ss_n), 32'hF);
    check("t5_rst_sck", 32'(sck), 32'd0);
    check("t5_rst_rx_valid", 32'(rx_valid), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    exp_rx.delete(); exp_mosi.delete(); slv_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clr_mon();
    send(8'h5A, 8'h00, 2'd2, 1'b1);
    wait_idle("t5");
    check("t5_nrise", 32'(nrise), 32'd8);

    // 6: tx_valid held across three single-word transfers
    lb = 1'b1; set_mode(1'b0, 1'b0, 1'b0, 8'd1); clr_mon();
    w6[0] = 8'h3E; w6[1] = 8'hC1; w6[2] = 8'h7B;
    for (int i = 0; i < 3; i++) begin exp_mosi.push_back(w6[i]); exp_rx.push_back(w6[i]); end
    @(posedge clk); #1;
    tx_valid = 1'b1; tx_data = w6[0]; tx_sel = 2'd1; tx_last = 1'b1;
    k = 0; n = 0;
    while (k < 3 && n < 3000) begin
      @(negedge clk); n++;
      if (tx_ready) begin
        @(posedge clk); #1;
        k++;
        if (k < 3) tx_data = w6[k];
        else tx_valid = 1'b0;
      end
    end
    tx_valid = 1'b0;
    wait_idle("t6");
    check("t6_accepts", 32'(accepts), 32'd3);
    check("t6_ready_while_sel", 32'(rdy_bad), 32'd0);
    check("t6_gap_ge_h", 32'(gap_min >= 2), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
